// File: rtl/rob_pr_free_q.sv
// rob_pr_free_q
//
// Buffers the physical registers released by ROB commit groups and returns
// them to a banked free list. Each queue entry holds one commit group: a PR
// per lane plus a pending mask of lanes that still have to be handed back.
// Only the head group is offered. Each bank takes the lowest-index pending
// lane whose PR maps to that bank. The head retires once every lane of the
// group has been accepted.
//
// Ports
//   CLK                    clock, all state updates on the rising edge
//   nRST                   asynchronous active-low reset
//   enq_valid              ROB presents a commit group
//   enq_valid_by_lane      per-lane dealloc valid
//   enq_PR_by_lane         per-lane PR to free
//   enq_ready              queue not full (independent of same-cycle drain)
//   free_valid_by_bank     a freed PR is offered to bank b
//   free_upper_PR_by_bank  upper PR bits (PR >> bank bits) offered to bank b
//   free_ready_by_bank     free-list bank b accepts this cycle

module rob_pr_free_q #(
    parameter int unsigned ROB_PR_FREE_Q_ENTRIES = 2,
    parameter int unsigned COMMIT_LANES          = 4,
    parameter int unsigned PR_COUNT              = 128,
    parameter int unsigned PRF_BANK_COUNT        = 4,
    localparam int unsigned PR_W                 = $clog2(PR_COUNT),
    localparam int unsigned BANK_W               = $clog2(PRF_BANK_COUNT),
    localparam int unsigned UPR_W                = PR_W - BANK_W
) (
    input  logic                                     CLK,
    input  logic                                     nRST,
    input  logic                                     enq_valid,
    input  logic [COMMIT_LANES-1:0]                  enq_valid_by_lane,
    input  logic [COMMIT_LANES-1:0][PR_W-1:0]        enq_PR_by_lane,
    output logic                                     enq_ready,
    output logic [PRF_BANK_COUNT-1:0]                free_valid_by_bank,
    output logic [PRF_BANK_COUNT-1:0][UPR_W-1:0]     free_upper_PR_by_bank,
    input  logic [PRF_BANK_COUNT-1:0]                free_ready_by_bank
);

    localparam int unsigned IDX_W = $clog2(ROB_PR_FREE_Q_ENTRIES);
    localparam int unsigned PTR_W = IDX_W + 1;

    // Pointers carry the wrap bit in their MSB; the queue depth is a power
    // of two, so a plain increment wraps the index and toggles the wrap bit.
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;

    logic [COMMIT_LANES-1:0][PR_W-1:0] pr_q   [ROB_PR_FREE_Q_ENTRIES];
    logic [COMMIT_LANES-1:0]           pend_q [ROB_PR_FREE_Q_ENTRIES];

    logic [IDX_W-1:0]                  head_idx;
    logic [IDX_W-1:0]                  tail_idx;
    logic                              empty;
    logic                              full;
    logic                              enq_fire;
    logic [COMMIT_LANES-1:0][PR_W-1:0] head_pr;
    logic [COMMIT_LANES-1:0]           head_pend;
    logic [COMMIT_LANES-1:0]           clr_mask;
    logic [COMMIT_LANES-1:0]           pend_d;
    logic                              head_done;

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign empty    = (head_q == tail_q);
    assign full     = (head_idx == tail_idx) && (head_q[PTR_W-1] != tail_q[PTR_W-1]);

    assign enq_ready = !full;
    // A group with no valid lanes is accepted but never stored.
    assign enq_fire  = enq_valid && enq_ready && (|enq_valid_by_lane);

    assign head_pr   = pr_q[head_idx];
    assign head_pend = empty ? '0 : pend_q[head_idx];

    // Per-bank selection: lowest-index pending lane mapped to the bank.
    // Because the pending mask only shrinks on acceptance, an offer stays
    // stable until its bank takes it.
    always_comb begin
        free_valid_by_bank    = '0;
        free_upper_PR_by_bank = '0;
        clr_mask              = '0;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            for (int l = 0; l < COMMIT_LANES; l++) begin
                if (!free_valid_by_bank[b] && head_pend[l] &&
                    (head_pr[l][BANK_W-1:0] == BANK_W'(b))) begin
                    free_valid_by_bank[b]    = 1'b1;
                    free_upper_PR_by_bank[b] = head_pr[l][PR_W-1:BANK_W];
                    if (free_ready_by_bank[b]) begin
                        clr_mask[l] = 1'b1;
                    end
                end
            end
        end
    end

    assign pend_d    = head_pend & ~clr_mask;
    assign head_done = !empty && (pend_d == '0);

    // When not full the tail entry never aliases a live head, so the head
    // drain and the enqueue write never target the same entry.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head_q <= '0;
            tail_q <= '0;
            for (int e = 0; e < ROB_PR_FREE_Q_ENTRIES; e++) begin
                pend_q[e] <= '0;
                pr_q[e]   <= '0;
            end
        end else begin
            if (!empty) begin
                pend_q[head_idx] <= pend_d;
            end
            if (head_done) begin
                head_q <= head_q + 1'b1;
            end
            if (enq_fire) begin
                pend_q[tail_idx] <= enq_valid_by_lane;
                pr_q[tail_idx]   <= enq_PR_by_lane;
                tail_q           <= tail_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rob_pr_free_q.sv
// Bench for rob_pr_free_q: directed vector table, an asynchronous reset
// sequence during a drain, then random traffic against a queue-based model.

module tb_rob_pr_free_q;

    localparam int ENTRIES = 2;
    localparam int LANES   = 4;
    localparam int BANKS   = 4;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             enq_valid;
    logic [3:0]       enq_valid_by_lane;
    logic [3:0][6:0]  enq_PR_by_lane;
    logic             enq_ready;
    logic [3:0]       free_valid_by_bank;
    logic [3:0][4:0]  free_upper_PR_by_bank;
    logic [3:0]       free_ready_by_bank;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    rob_pr_free_q #(
        .ROB_PR_FREE_Q_ENTRIES (ENTRIES),
        .COMMIT_LANES          (LANES),
        .PR_COUNT              (128),
        .PRF_BANK_COUNT        (BANKS)
    ) dut (
        .CLK                   (CLK),
        .nRST                  (nRST),
        .enq_valid             (enq_valid),
        .enq_valid_by_lane     (enq_valid_by_lane),
        .enq_PR_by_lane        (enq_PR_by_lane),
        .enq_ready             (enq_ready),
        .free_valid_by_bank    (free_valid_by_bank),
        .free_upper_PR_by_bank (free_upper_PR_by_bank),
        .free_ready_by_bank    (free_ready_by_bank)
    );

    typedef struct packed {
        logic        ev;
        logic [3:0]  lanes;
        logic [27:0] prs;
        logic [3:0]  rdy;
        logic        exp_ready;
        logic [3:0]  exp_valid;
        logic [19:0] exp_upr;
    } vec_t;

    typedef struct packed {
        logic [3:0]  pend;
        logic [27:0] pr;
    } grp_t;

    vec_t vecs[23];
    grp_t mq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic ev, input logic [3:0] lanes, input logic [27:0] prs,
                          input logic [3:0] rdy);
        enq_valid          = ev;
        enq_valid_by_lane  = lanes;
        enq_PR_by_lane     = prs;
        free_ready_by_bank = rdy;
    endtask

    task automatic check_outs(input string tag, input logic er, input logic [3:0] ev,
                              input logic [19:0] eu);
        check({tag, " enq_ready"}, 32'(enq_ready), 32'(er));
        check({tag, " free_valid"}, 32'(free_valid_by_bank), 32'(ev));
        check({tag, " free_upper"}, 32'(free_upper_PR_by_bank), 32'(eu));
    endtask

    function automatic vec_t mk(input logic ev, input logic [3:0] lanes, input logic [27:0] prs,
                                input logic [3:0] rdy, input logic er, input logic [3:0] evl,
                                input logic [19:0] eu);
        vec_t v;
        v.ev = ev; v.lanes = lanes; v.prs = prs; v.rdy = rdy;
        v.exp_ready = er; v.exp_valid = evl; v.exp_upr = eu;
        return v;
    endfunction

    logic            m_ready;
    logic [3:0]      m_valid;
    logic [3:0][4:0] m_upr;
    logic [3:0]      taken;
    grp_t            g;
    logic            rev;
    logic [3:0]      rl;
    logic [3:0]      rr;
    logic [27:0]     rp;
    int              sz;

    initial begin
        // One group per cycle; expectations are the outputs seen during that cycle.
        // All four banks at once, then empty.
        vecs[0]  = mk(1, 4'b1111, {7'h13, 7'h0E, 7'h09, 7'h04}, 4'hF, 1, 4'b0000, 20'd0);
        vecs[1]  = mk(0, 4'b0000, 28'd0, 4'hF, 1, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1});
        vecs[2]  = mk(0, 4'b0000, 28'd0, 4'hF, 1, 4'b0000, 20'd0);
        // Three lanes on bank0: one per cycle, bank1 only on the first.
        vecs[3]  = mk(1, 4'b1111, {7'h01, 7'h10, 7'h0C, 7'h08}, 4'hF, 1, 4'b0000, 20'd0);
        vecs[4]  = mk(0, 4'b0000, 28'd0, 4'hF, 1, 4'b0011, {5'd0, 5'd0, 5'd0, 5'd2});
        vecs[5]  = mk(0, 4'b0000, 28'd0, 4'hF, 1, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd3});
        vecs[6]  = mk(0, 4'b0000, 28'd0, 4'hF, 1, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd4});
        vecs[7]  = mk(0, 4'b0000, 28'd0, 4'hF, 1, 4'b0000, 20'd0);
        // Fill while blocked, third enqueue ignored, then in-order drain.
        vecs[8]  = mk(1, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h05}, 4'h0, 1, 4'b0000, 20'd0);
        vecs[9]  = mk(1, 4'b0010, {7'h00, 7'h00, 7'h0A, 7'h00}, 4'h0, 1, 4'b0010,
                      {5'd0, 5'd0, 5'd1, 5'd0});
        vecs[10] = mk(1, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h03}, 4'h0, 0, 4'b0010,
                      {5'd0, 5'd0, 5'd1, 5'd0});
        vecs[11] = mk(0, 4'b0000, 28'd0, 4'hF, 0, 4'b0010, {5'd0, 5'd0, 5'd1, 5'd0});
        vecs[12] = mk(0, 4'b0000, 28'd0, 4'hF, 1, 4'b0100, {5'd0, 5'd2, 5'd0, 5'd0});
        vecs[13] = mk(0, 4'b0000, 28'd0, 4'hF, 1, 4'b0000, 20'd0);
        // Group with no valid lanes is not stored.
        vecs[14] = mk(1, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'hF, 1, 4'b0000, 20'd0);
        vecs[15] = mk(0, 4'b0000, 28'd0, 4'hF, 1, 4'b0000, 20'd0);
        // Held offer under back-pressure, then enqueue during head drain.
        vecs[16] = mk(1, 4'b0011, {7'h00, 7'h00, 7'h08, 7'h04}, 4'hF, 1, 4'b0000, 20'd0);
        vecs[17] = mk(1, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h07}, 4'h0, 1, 4'b0001,
                      {5'd0, 5'd0, 5'd0, 5'd1});
        vecs[18] = mk(0, 4'b0000, 28'd0, 4'b0001, 0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd1});
        vecs[19] = mk(0, 4'b0000, 28'd0, 4'hF, 0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd2});
        vecs[20] = mk(1, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h02}, 4'hF, 1, 4'b1000,
                      {5'd1, 5'd0, 5'd0, 5'd0});
        vecs[21] = mk(0, 4'b0000, 28'd0, 4'hF, 1, 4'b0100, 20'd0);
        vecs[22] = mk(0, 4'b0000, 28'd0, 4'hF, 1, 4'b0000, 20'd0);

        set_in(1'b0, 4'b0, 28'd0, 4'b0);
        nRST = 1'b1;
        #1 nRST = 1'b0;
        #2 check_outs("reset", 1'b1, 4'b0000, 20'd0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 23; i++) begin
            set_in(vecs[i].ev, vecs[i].lanes, vecs[i].prs, vecs[i].rdy);
            @(negedge CLK);
            check_outs($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_valid,
                       vecs[i].exp_upr);
            @(posedge CLK);
            #1;
        end

        // Reset in the middle of a conflicting drain.
        set_in(1'b1, 4'b1111, {7'h01, 7'h10, 7'h0C, 7'h08}, 4'hF);
        @(posedge CLK);
        #1 set_in(1'b0, 4'b0, 28'd0, 4'hF);
        @(negedge CLK);
        check_outs("pre_rst", 1'b1, 4'b0011, {5'd0, 5'd0, 5'd0, 5'd2});
        @(posedge CLK);
        #2 nRST = 1'b0;
        #1 check_outs("mid_rst", 1'b1, 4'b0000, 20'd0);
        @(negedge CLK);
        nRST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check_outs($sformatf("post_rst%0d", i), 1'b1, 4'b0000, 20'd0);
        end
        @(posedge CLK);
        #1;

        // Random traffic against a queue-of-groups model.
        for (int c = 0; c < 600; c++) begin
            rev = 1'($urandom_range(0, 1));
            rl  = ($urandom_range(0, 5) == 0) ? 4'b0 : 4'($urandom);
            rp  = 28'($urandom);
            for (int b = 0; b < BANKS; b++) rr[b] = ($urandom_range(0, 9) < 6);
            set_in(rev, rl, rp, rr);
            @(negedge CLK);

            m_ready = (mq.size() < ENTRIES);
            m_valid = '0;
            m_upr   = '0;
            taken   = '0;
            if (mq.size() > 0) begin
                g = mq[0];
                for (int b = 0; b < BANKS; b++) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (!m_valid[b] && g.pend[l] && (int'(g.pr[l*7 +: 7]) % BANKS) == b) begin
                            m_valid[b] = 1'b1;
                            m_upr[b]   = 5'(int'(g.pr[l*7 +: 7]) / BANKS);
                            if (rr[b]) taken[l] = 1'b1;
                        end
                    end
                end
            end
            check_outs($sformatf("rnd%0d", c), m_ready, m_valid, m_upr);

            @(posedge CLK);
            sz = mq.size();
            if (sz > 0) begin
                g.pend = g.pend & ~taken;
                if (g.pend == 4'b0) void'(mq.pop_front());
                else mq[0] = g;
            end
            if (rev && sz < ENTRIES && rl != 4'b0) mq.push_back({rl, rp});
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
